// File: rtl/branch_pkg.sv
// -----------------------------------------------------------------------------
// branch_pkg
// Shared types and constants for the branch controller slice.
//   - cond_e  : branch condition codes, evaluated on the registered flags
//   - state_e : run-control FSM states
//   - flags_t : registered ALU flag set {z, n, c}
//   - LUT_*   : target-source select encodings (3 also behaves as relative)
// No ports; imported by branch_ctrl_if, cond_eval and branch_ctrl.
// -----------------------------------------------------------------------------
package branch_pkg;

    localparam int PC_W  = 10;
    localparam int OFF_W = 8;

    localparam logic [1:0] LUT_REL = 2'd0;
    localparam logic [1:0] LUT_L2  = 2'd1;
    localparam logic [1:0] LUT_L3  = 2'd2;

    typedef enum logic [2:0] {
        ALWAYS = 3'd0,
        EQ     = 3'd1,
        NE     = 3'd2,
        LT     = 3'd3,
        GE     = 3'd4,
        CS     = 3'd5,
        CC     = 3'd6,
        NEVER  = 3'd7
    } cond_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        RUN    = 2'd2,
        HALT   = 2'd3
    } state_e;

    typedef struct packed {
        logic z;
        logic n;
        logic c;
    } flags_t;

endpackage

// File: rtl/branch_ctrl_if.sv
// -----------------------------------------------------------------------------
// branch_ctrl_if
// Groups the decode/ALU-side inputs and PC-side outputs of branch_ctrl.
//   master : driven by decode/ALU (go, pc, is_branch, cond, offset, lut_sel,
//            flag_we, alu_z/n/c); observes the PC-side outputs
//   slave  : branch_ctrl side; drives start, branch, taken, target, LOOKUP2,
//            LOOKUP3, done, running
// With BRANCH_STATS_EN defined, br_count/taken_count are added to the bundle.
// -----------------------------------------------------------------------------
interface branch_ctrl_if
    import branch_pkg::*;
#(
    parameter int IF_PC_W  = PC_W,
    parameter int IF_OFF_W = OFF_W
);
    logic                go;
    logic [IF_PC_W-1:0]  pc;
    logic                is_branch;
    logic [2:0]          cond;
    logic [IF_OFF_W-1:0] offset;
    logic [1:0]          lut_sel;
    logic                flag_we;
    logic                alu_z;
    logic                alu_n;
    logic                alu_c;

    logic                start;
    logic                branch;
    logic                taken;
    logic [IF_OFF_W-1:0] target;
    logic                LOOKUP2;
    logic                LOOKUP3;
    logic                done;
    logic                running;
`ifdef BRANCH_STATS_EN
    logic [15:0]         br_count;
    logic [15:0]         taken_count;
`endif

    modport master (
        output go, pc, is_branch, cond, offset, lut_sel, flag_we, alu_z, alu_n, alu_c,
        input  start, branch, taken, target, LOOKUP2, LOOKUP3, done, running
`ifdef BRANCH_STATS_EN
        , input br_count, taken_count
`endif
    );

    modport slave (
        input  go, pc, is_branch, cond, offset, lut_sel, flag_we, alu_z, alu_n, alu_c,
        output start, branch, taken, target, LOOKUP2, LOOKUP3, done, running
`ifdef BRANCH_STATS_EN
        , output br_count, taken_count
`endif
    );

endinterface

// File: rtl/cond_eval.sv
// -----------------------------------------------------------------------------
// cond_eval
// Purely combinational condition evaluator.
//   flags     : registered {z, n, c}
//   cond      : condition code
//   cond_true : 1 when the condition holds (NEVER is always 0)
// -----------------------------------------------------------------------------
module cond_eval
    import branch_pkg::*;
(
    input  flags_t flags,
    input  cond_e  cond,
    output logic   cond_true
);

    always_comb begin
        cond_true = 1'b0;
        case (cond)
            ALWAYS:  cond_true = 1'b1;
            EQ:      cond_true = flags.z;
            NE:      cond_true = ~flags.z;
            LT:      cond_true = flags.n;
            GE:      cond_true = ~flags.n;
            CS:      cond_true = flags.c;
            CC:      cond_true = ~flags.c;
            default: cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_ctrl.sv
// -----------------------------------------------------------------------------
// branch_ctrl
// Control-side PC driver: run-control FSM (IDLE/LAUNCH/RUN/HALT), registered
// ALU flag set, and combinational branch outputs while in RUN.
//   CLK    : clock, rising edge
//   RST_N  : asynchronous active-low reset
//   bus    : branch_ctrl_if.slave (decode/ALU inputs, PC-side outputs)
// Optional macro BRANCH_STATS_EN adds saturating 16-bit br_count/taken_count.
// -----------------------------------------------------------------------------
module branch_ctrl
    import branch_pkg::*;
#(
    parameter int              PC_W      = branch_pkg::PC_W,
    parameter int              OFF_W     = branch_pkg::OFF_W,
    parameter logic [PC_W-1:0] HALT_ADDR = 10'd1023
)(
    input  logic              CLK,
    input  logic              RST_N,
    branch_ctrl_if.slave      bus
);

    state_e state_q, state_d;
    flags_t flags_q, flags_d;
    logic   done_q,  done_d;
    logic   cond_true;
    logic   in_run;
    logic   taken_w;

    cond_eval u_cond_eval (
        .flags     (flags_q),
        .cond      (cond_e'(bus.cond)),
        .cond_true (cond_true)
    );

    // Next state and flag update. Flags load only in RUN and are wiped on the
    // HALT->LAUNCH restart so a new program never sees stale flags.
    always_comb begin
        state_d = state_q;
        flags_d = flags_q;
        case (state_q)
            IDLE: begin
                if (bus.go) state_d = LAUNCH;
            end
            LAUNCH: begin
                state_d = RUN;
            end
            RUN: begin
                if (bus.flag_we) flags_d = '{z: bus.alu_z, n: bus.alu_n, c: bus.alu_c};
                if (bus.pc == HALT_ADDR) state_d = HALT;
            end
            HALT: begin
                if (bus.go) begin
                    state_d = LAUNCH;
                    flags_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        done_d = (state_d == HALT);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            flags_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
            done_q  <= done_d;
        end
    end

    // Branch outputs use flags from before the edge (no forwarding) and are
    // gated by RUN, so they fall as soon as the async reset clears state_q.
    always_comb begin
        in_run      = (state_q == RUN);
        taken_w     = in_run & bus.is_branch & cond_true;
        bus.start   = (state_q == LAUNCH);
        bus.running = in_run;
        bus.done    = done_q;
        bus.branch  = in_run & bus.is_branch;
        bus.taken   = taken_w;
        bus.target  = in_run ? bus.offset : {OFF_W{1'b0}};
        bus.LOOKUP2 = taken_w & (bus.lut_sel == LUT_L2);
        bus.LOOKUP3 = taken_w & (bus.lut_sel == LUT_L3);
    end

`ifdef BRANCH_STATS_EN
    logic [15:0] br_count_q, br_count_d;
    logic [15:0] taken_count_q, taken_count_d;

    // Counters restart on every LAUNCH entry and saturate rather than wrap.
    always_comb begin
        br_count_d    = br_count_q;
        taken_count_d = taken_count_q;
        if (state_d == LAUNCH && state_q != LAUNCH) begin
            br_count_d    = '0;
            taken_count_d = '0;
        end else if (in_run) begin
            if (bus.is_branch && br_count_q != 16'hFFFF) br_count_d = br_count_q + 16'd1;
            if (taken_w && taken_count_q != 16'hFFFF) taken_count_d = taken_count_q + 16'd1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            br_count_q    <= '0;
            taken_count_q <= '0;
        end else begin
            br_count_q    <= br_count_d;
            taken_count_q <= taken_count_d;
        end
    end

    assign bus.br_count    = br_count_q;
    assign bus.taken_count = taken_count_q;
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_branch_ctrl
// Directed testbench for branch_ctrl. Stimulus pushes hand-computed expected
// outputs into a scoreboard queue; a monitor on the falling edge pops and
// compares against the DUT outputs.
// Expected vector layout: {start, branch, taken, LOOKUP2, LOOKUP3, done,
// running, target[7:0]}.
// -----------------------------------------------------------------------------
module tb_branch_ctrl;
    import branch_pkg::*;

    logic CLK;
    logic RST_N;

    branch_ctrl_if bus ();

    branch_ctrl dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        logic [14:0] vec;
        bit          cnt_chk;
        logic [15:0] br_cnt;
        logic [15:0] tk_cnt;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [14:0] mk(bit st, bit br, bit tk, bit l2, bit l3,
                                       bit dn, bit rn, logic [7:0] tg);
        return {st, br, tk, l2, l3, dn, rn, tg};
    endfunction

    task automatic push(string nm, logic [14:0] v);
        exp_t e;
        e.name = nm; e.vec = v; e.cnt_chk = 1'b0; e.br_cnt = '0; e.tk_cnt = '0;
        sb_q.push_back(e);
    endtask

    task automatic push_cnt(string nm, logic [14:0] v, logic [15:0] bc, logic [15:0] tc);
        exp_t e;
        e.name = nm; e.vec = v; e.cnt_chk = 1'b1; e.br_cnt = bc; e.tk_cnt = tc;
        sb_q.push_back(e);
    endtask

    task automatic apply_stimulus(bit go_v, bit br_v, logic [2:0] c, logic [7:0] off,
                                  logic [1:0] ls, bit we, bit z, bit n, bit cf);
        bus.go        = go_v;
        bus.is_branch = br_v;
        bus.cond      = c;
        bus.offset    = off;
        bus.lut_sel   = ls;
        bus.flag_we   = we;
        bus.alu_z     = z;
        bus.alu_n     = n;
        bus.alu_c     = cf;
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    // Monitor: compare everything queued for this cycle on the falling edge.
    always @(negedge CLK) begin
        exp_t        e;
        logic [14:0] act;
        while (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            act = {bus.start, bus.branch, bus.taken, bus.LOOKUP2, bus.LOOKUP3,
                   bus.done, bus.running, bus.target};
            checks++;
            if (act !== e.vec) begin
                errors++;
                $display("[TB] FAIL %s: got %h expected %h", e.name, act, e.vec);
            end
`ifdef BRANCH_STATS_EN
            if (e.cnt_chk) begin
                checks++;
                if (bus.br_count !== e.br_cnt || bus.taken_count !== e.tk_cnt) begin
                    errors++;
                    $display("[TB] FAIL %s_counts: got %h/%h expected %h/%h", e.name,
                             bus.br_count, bus.taken_count, e.br_cnt, e.tk_cnt);
                end
            end
`endif
        end
    end

    initial begin
        RST_N  = 1'b0;
        bus.pc = '0;
        apply_stimulus(0, 0, 3'd0, 8'h00, 2'd0, 0, 0, 0, 0);
        repeat (2) next_cycle();
        push_cnt("reset", mk(0,0,0,0,0,0,0,8'h00), 16'd0, 16'd0);
        next_cycle();

        RST_N = 1'b1;
        apply_stimulus(1, 0, 3'd0, 8'h00, 2'd0, 0, 0, 0, 0);
        push("idle_go", mk(0,0,0,0,0,0,0,8'h00));
        next_cycle();

        apply_stimulus(0, 0, 3'd0, 8'h00, 2'd0, 0, 0, 0, 0);
        push("launch", mk(1,0,0,0,0,0,0,8'h00));
        next_cycle();

        apply_stimulus(0, 0, 3'd0, 8'h00, 2'd0, 1, 1, 0, 0);
        push("run_entry", mk(0,0,0,0,0,0,1,8'h00));
        next_cycle();

        apply_stimulus(0, 1, 3'd1, 8'h05, 2'd0, 0, 0, 0, 0);
        push("beq_taken", mk(0,1,1,0,0,0,1,8'h05));
        next_cycle();

        apply_stimulus(0, 1, 3'd2, 8'h12, 2'd0, 1, 0, 0, 0);
        push("bne_old_flags", mk(0,1,0,0,0,0,1,8'h12));
        next_cycle();

        apply_stimulus(0, 1, 3'd2, 8'h12, 2'd1, 0, 0, 0, 0);
        push("bne_new_flags_l2", mk(0,1,1,1,0,0,1,8'h12));
        next_cycle();

        apply_stimulus(0, 0, 3'd0, 8'h33, 2'd0, 1, 0, 1, 0);
        push("no_branch_target", mk(0,0,0,0,0,0,1,8'h33));
        next_cycle();

        apply_stimulus(0, 1, 3'd3, 8'hA0, 2'd2, 0, 0, 0, 0);
        push("bmi_l3", mk(0,1,1,0,1,0,1,8'hA0));
        next_cycle();

        apply_stimulus(0, 1, 3'd7, 8'hA0, 2'd2, 0, 0, 0, 0);
        push("never_l3", mk(0,1,0,0,0,0,1,8'hA0));
        next_cycle();

        apply_stimulus(0, 1, 3'd0, 8'h7F, 2'd3, 0, 0, 0, 0);
        push("always_sel3_rel", mk(0,1,1,0,0,0,1,8'h7F));
        next_cycle();

        apply_stimulus(0, 1, 3'd6, 8'h7F, 2'd1, 0, 0, 0, 0);
        push("bcc_l2", mk(0,1,1,1,0,0,1,8'h7F));
        next_cycle();

        apply_stimulus(1, 1, 3'd4, 8'h7F, 2'd1, 0, 0, 0, 0);
        push("bge_false_go_run", mk(0,1,0,0,0,0,1,8'h7F));
        next_cycle();

        apply_stimulus(0, 0, 3'd0, 8'h00, 2'd0, 0, 0, 0, 0);
        push("go_ignored", mk(0,0,0,0,0,0,1,8'h00));
        next_cycle();

        bus.pc = 10'd1023;
        apply_stimulus(0, 1, 3'd0, 8'h04, 2'd0, 0, 0, 0, 0);
        push("halt_cycle_branch", mk(0,1,1,0,0,0,1,8'h04));
        next_cycle();

        push("halted", mk(0,0,0,0,0,1,0,8'h00));
        next_cycle();

        apply_stimulus(1, 1, 3'd0, 8'h04, 2'd0, 0, 0, 0, 0);
        push("halt_go", mk(0,0,0,0,0,1,0,8'h00));
        next_cycle();

        bus.pc = '0;
        apply_stimulus(0, 0, 3'd0, 8'h00, 2'd0, 0, 0, 0, 0);
        push_cnt("relaunch", mk(1,0,0,0,0,0,0,8'h00), 16'd0, 16'd0);
        next_cycle();

        apply_stimulus(0, 1, 3'd3, 8'h10, 2'd0, 0, 0, 0, 0);
        push("flags_cleared_n", mk(0,1,0,0,0,0,1,8'h10));
        next_cycle();

        apply_stimulus(0, 1, 3'd2, 8'h10, 2'd0, 0, 0, 0, 0);
        push_cnt("flags_cleared_z", mk(0,1,1,0,0,0,1,8'h10), 16'd1, 16'd0);
        next_cycle();

        apply_stimulus(0, 1, 3'd0, 8'h55, 2'd1, 0, 0, 0, 0);
        #2 RST_N = 1'b0;
        push_cnt("async_reset", mk(0,0,0,0,0,0,0,8'h00), 16'd0, 16'd0);
        next_cycle();

        RST_N = 1'b1;
        push("post_reset_idle", mk(0,0,0,0,0,0,0,8'h00));
        next_cycle();

        push("idle_stays", mk(0,0,0,0,0,0,0,8'h00));
        next_cycle();

        next_cycle();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_ctrl.md
Name: branch_ctrl

Overview:
- Control-side driver for the program counter: evaluates branch conditions against a registered ALU flag set and produces branch, taken, target, LOOKUP2, LOOKUP3 and start for the PC.
- Sits between decode/ALU and the PC.
- Owns the run-control FSM (idle, launch, run, halt) and raises done when the PC reaches the halt address.

Parameters:
- PC_W, 10, PC width; matches the PC output.
- OFF_W, 8, branch offset width; matches the PC target input.
- HALT_ADDR, 10'd1023, PC value that ends the program.

Ports:
- CLK  input  1  clock, rising edge
- RST_N  input  1  asynchronous, active-low reset
- go  input  1  request program run; sampled in IDLE and HALT
- pc  input  PC_W  current PC value
- is_branch  input  1  decoded instruction is a branch
- cond  input  3  branch condition code
- offset  input  OFF_W  relative target from instruction
- lut_sel  input  2  target source: 0 relative, 1 LOOKUP2, 2 LOOKUP3, 3 relative
- flag_we  input  1  write ALU flags this cycle
- alu_z, alu_n, alu_c  input  1 each  ALU zero, negative, carry
- start  output  1  PC start/increment strobe
- branch  output  1  branch instruction valid to PC
- taken  output  1  condition true
- target  output  OFF_W  offset to PC
- LOOKUP2  output  1  select fixed target 2
- LOOKUP3  output  1  select fixed target 3
- done  output  1  program halted
- running  output  1  FSM in RUN

Behaviour:
- Reset is asynchronous, active-low; CLK is the only clock. On reset: FSM=IDLE; flags Z=N=C=0; all outputs 0.
- FSM:
  - IDLE -> LAUNCH when go=1.
  - LAUNCH lasts 1 cycle; start=1 -> RUN.
  - RUN -> HALT when pc==HALT_ADDR.
  - HALT -> LAUNCH when go=1; flags are cleared on that transition.
- Flag register: on a CLK edge with flag_we=1 and state RUN, {Z,N,C} <= {alu_z,alu_n,alu_c}. Otherwise the flags hold.
- Condition codes, evaluated on the registered flags:
  - 0 always, 1 Z, 2 !Z, 3 N, 4 !N, 5 C, 6 !C, 7 never.
- Outputs in RUN are combinational, 0-cycle latency; the PC registers them:
  - branch=is_branch; taken=is_branch & cond_true; target=offset unmodified.
  - LOOKUP2=taken & (lut_sel==1); LOOKUP3=taken & (lut_sel==2). The two are mutually exclusive.
- Outside RUN: branch, taken, LOOKUP2, LOOKUP3 are forced to 0 and target to 0.
- done is registered: set on entering HALT, cleared on leaving HALT. running=(state==RUN).
- Simultaneous flag_we and is_branch: the branch uses flags from before the edge. No forwarding, because the compare instruction precedes the branch.
- pc==HALT_ADDR while is_branch=1: the halt wins; branch is suppressed from the next cycle.
- go while in RUN or LAUNCH: ignored.
- RST_N low mid-run: immediate return to IDLE; outputs drop asynchronously.
- lut_sel=3 behaves as relative. cond=7 never asserts taken, even with a LOOKUP select.

Optional Feature:
- Macro BRANCH_STATS_EN.
- When defined, adds outputs br_count (16) and taken_count (16):
  - increment on each RUN cycle with branch=1 and taken=1 respectively;
  - saturate at 16'hFFFF;
  - clear on reset and on entry to LAUNCH.
- When undefined, the ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Package branch_pkg: cond_e enum (ALWAYS, EQ, NE, LT, GE, CS, CC, NEVER); lut_sel constants (LUT_REL, LUT_L2, LUT_L3); state_e (IDLE, LAUNCH, RUN, HALT); flags_t struct {z,n,c}.
- One natural sub-module: cond_eval, a combinational flags_t + cond_e -> cond_true function block. FSM and flag register stay in branch_ctrl.

Test Plan:
- Reset then go=1 one cycle -> LAUNCH with start=1 for exactly 1 cycle, then running=1; done=0.
- flag_we=1 with alu_z=1; next cycle is_branch=1, cond=1, offset=8'h05, lut_sel=0 -> branch=1, taken=1, target=8'h05, LOOKUP2=LOOKUP3=0.
- Same cycle flag_we=1 (alu_z=0) and is_branch=1, cond=2 with old Z=1 -> taken=0; the next branch with cond=2 -> taken=1.
- Flags N=1, branch cond=3, lut_sel=2 -> taken=1, LOOKUP3=1; repeat with cond=7 -> taken=0, LOOKUP3=0.
- pc driven to HALT_ADDR with is_branch=1 -> next cycle done=1, running=0, branch=0; go=1 -> start pulse, flags cleared to 0.
- RST_N low mid-RUN, asynchronous to CLK -> all outputs 0 immediately; FSM IDLE after release; with BRANCH_STATS_EN, counters read 0.
